// File: rtl/seq_modulo_reduce_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_modulo_reduce_pkg                                           |
// | Brief    : State encoding and index-width helpers for seq_modulo_reduce.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package seq_modulo_reduce_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // A single-entry range still needs a one-bit index.
  function automatic int slice_idx_w(input int num_slices);
    return (num_slices > 1) ? $clog2(num_slices) : 1;
  endfunction

  function automatic int bit_idx_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_bit_step.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mod_bit_step                                                    |
// | Brief    : One restoring-remainder step: shift in a bit, trial-subtract d. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module mod_bit_step #(
  parameter int WIDTH = 10
) (
  input  logic [WIDTH-1:0] rem,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] rem_next,
  output logic             sub
);

  logic [WIDTH:0]   w_shift;
  logic [WIDTH-1:0] w_diff;

  // The compare needs the carry-out bit; the kept difference is always < d,
  // so it fits in WIDTH bits and modular low-half subtraction is exact.
  assign w_shift  = {rem, bit_in};
  assign sub      = (w_shift >= {1'b0, d});
  assign w_diff   = w_shift[WIDTH-1:0] - d;
  assign rem_next = sub ? w_diff : w_shift[WIDTH-1:0];

endmodule
`default_nettype wire

// File: rtl/seq_modulo_reduce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seq_modulo_reduce                                               |
// | Brief    : Chained modulo over NUM_SLICES divisors, one bit per clock.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module seq_modulo_reduce
  import seq_modulo_reduce_pkg::*;
#(
  parameter int WIDTH      = 10,
  parameter int NUM_SLICES = 48
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [WIDTH-1:0]            init,
  input  logic [NUM_SLICES*WIDTH-1:0] b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            a,
  output logic                        div_zero
);

  localparam int c_slice_w = slice_idx_w(NUM_SLICES);
  localparam int c_bit_w   = bit_idx_w(WIDTH);
  localparam logic [c_slice_w-1:0] c_last_slice = c_slice_w'(NUM_SLICES - 1);
  localparam logic [c_bit_w-1:0]   c_top_bit    = c_bit_w'(WIDTH - 1);

  state_t r_state;
  state_t w_state_next;

  logic [NUM_SLICES*WIDTH-1:0] r_slices;
  logic [WIDTH-1:0]            r_acc;
  logic [WIDTH-1:0]            r_rem;
  logic [WIDTH-1:0]            r_a;
  logic                        r_zero;
  logic                        r_div_zero;
  logic                        r_sub_seen;
  logic [c_slice_w-1:0]        r_slice_idx;
  logic [c_bit_w-1:0]          r_bit_idx;

  logic [WIDTH-1:0] w_slice [NUM_SLICES];
  logic [WIDTH-1:0] w_d;
  logic             w_bit;
  logic [WIDTH-1:0] w_rem_next;
  logic             w_sub;
  logic             w_d_zero;
  logic             w_last_bit;
  logic             w_last_slice;
  logic [WIDTH-1:0] w_slice_result;

  generate
    for (genvar k = 0; k < NUM_SLICES; k++) begin : g_unpack
      assign w_slice[k] = r_slices[k*WIDTH +: WIDTH];
    end
  endgenerate

  assign w_d          = w_slice[r_slice_idx];
  assign w_bit        = r_acc[r_bit_idx];
  assign w_d_zero     = (w_d == '0);
  assign w_last_bit   = (r_bit_idx == '0);
  assign w_last_slice = (r_slice_idx == c_last_slice);

  mod_bit_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem      (r_rem),
    .bit_in   (w_bit),
    .d        (w_d),
    .rem_next (w_rem_next),
    .sub      (w_sub)
  );

  // A zero divisor acts as identity; if no step ever subtracted, the shifted
  // remainder equals acc anyway, so acc is only rewritten when it changed.
  assign w_slice_result = (!w_d_zero && (r_sub_seen || w_sub)) ? w_rem_next : r_acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_state_next = CALC;
        end
      end
      CALC: begin
        if (w_last_bit && w_last_slice) begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_slices    <= '0;
      r_acc       <= '0;
      r_rem       <= '0;
      r_a         <= '0;
      r_zero      <= 1'b0;
      r_div_zero  <= 1'b0;
      r_sub_seen  <= 1'b0;
      r_slice_idx <= '0;
      r_bit_idx   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_acc       <= init;
            r_slices    <= b;
            r_rem       <= '0;
            r_zero      <= 1'b0;
            r_sub_seen  <= 1'b0;
            r_slice_idx <= '0;
            r_bit_idx   <= c_top_bit;
          end
        end
        CALC: begin
          if (w_last_bit) begin
            r_acc       <= w_slice_result;
            r_rem       <= '0;
            r_sub_seen  <= 1'b0;
            r_zero      <= r_zero | w_d_zero;
            r_bit_idx   <= c_top_bit;
            r_slice_idx <= r_slice_idx + c_slice_w'(1);
            if (w_last_slice) begin
              r_a        <= w_slice_result;
              r_div_zero <= r_zero | w_d_zero;
            end
          end else begin
            r_rem      <= w_rem_next;
            r_sub_seen <= r_sub_seen | w_sub;
            r_bit_idx  <= r_bit_idx - c_bit_w'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign a        = r_a;
  assign div_zero = r_div_zero;

endmodule
`default_nettype wire

// File: tb/tb_seq_modulo_reduce.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seq_modulo_reduce                                            |
// | Brief    : Directed and random scoreboard bench for seq_modulo_reduce.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_seq_modulo_reduce;

  localparam int TW = 10;
  localparam int TN = 48;
  localparam int SW = 4;
  localparam int SN = 3;

  typedef struct packed {
    logic [TW-1:0] a;
    logic          dz;
  } exp_t;

  typedef struct packed {
    logic [SW-1:0] a;
    logic          dz;
  } sexp_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready, out_valid, out_ready, div_zero;
  logic [TW-1:0]    init, a;
  logic [TN*TW-1:0] b;

  logic             s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_div_zero;
  logic [SW-1:0]    s_init, s_a;
  logic [SN*SW-1:0] s_b;

  int unsigned pass_cnt  = 0;
  int unsigned fail_cnt  = 0;
  int unsigned total_cnt = 0;

  exp_t  q[$];
  sexp_t sq[$];
  exp_t  last_exp;

  always #5 clk = ~clk;

  seq_modulo_reduce #(.WIDTH(TW), .NUM_SLICES(TN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .init(init), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .div_zero(div_zero)
  );

  seq_modulo_reduce #(.WIDTH(SW), .NUM_SLICES(SN)) dut_s (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .init(s_init), .b(s_b), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .a(s_a), .div_zero(s_div_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t ref10(input logic [TW-1:0] i, input logic [TN*TW-1:0] bv);
    exp_t r;
    logic [TW-1:0] d;
    r.a  = i;
    r.dz = 1'b0;
    for (int k = 0; k < TN; k++) begin
      d = bv[k*TW +: TW];
      if (d == '0) r.dz = 1'b1;
      else         r.a  = r.a % d;
    end
    return r;
  endfunction

  function automatic sexp_t ref4(input logic [SW-1:0] i, input logic [SN*SW-1:0] bv);
    sexp_t r;
    logic [SW-1:0] d;
    r.a  = i;
    r.dz = 1'b0;
    for (int k = 0; k < SN; k++) begin
      d = bv[k*SW +: SW];
      if (d == '0) r.dz = 1'b1;
      else         r.a  = r.a % d;
    end
    return r;
  endfunction

  function automatic logic [TN*TW-1:0] mk(input int s0, input int s1, input int rest);
    logic [TN*TW-1:0] v;
    v = '0;
    v[0 +: TW]  = TW'(s0);
    v[TW +: TW] = TW'(s1);
    for (int k = 2; k < TN; k++) v[k*TW +: TW] = TW'(rest);
    return v;
  endfunction

  // Entered and left at posedge+1; the accepting edge is the last edge waited on.
  task automatic start_job(input logic [TW-1:0] i, input logic [TN*TW-1:0] bv);
    int n;
    init = i;
    b = bv;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 2000) begin
      @(posedge clk); #1; n++;
    end
    check("accept_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    q.push_back(ref10(i, bv));
  endtask

  task automatic wait_result(input string tag);
    int cycles;
    exp_t e;
    cycles = 0;
    while (!out_valid && cycles < 2000) begin
      @(posedge clk); #1; cycles++;
    end
    check({tag, "_latency"}, cycles, TW*TN);
    e = (q.size() > 0) ? q.pop_front() : '0;
    last_exp = e;
    check({tag, "_a"}, {22'd0, a}, {22'd0, e.a});
    check({tag, "_div_zero"}, {31'd0, div_zero}, {31'd0, e.dz});
  endtask

  task automatic finish_job(input string tag);
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    check({tag, "_idle_valid"}, {31'd0, out_valid}, 32'd0);
  endtask

  task automatic run_job(input string tag, input logic [TW-1:0] i, input logic [TN*TW-1:0] bv);
    start_job(i, bv);
    wait_result(tag);
    finish_job(tag);
  endtask

  task automatic sweep_job(input int idx);
    int cycles;
    sexp_t e;
    s_init = SW'($urandom_range(0, 15));
    for (int k = 0; k < SN; k++) s_b[k*SW +: SW] = SW'($urandom_range(0, 15));
    s_in_valid = 1'b1;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    sq.push_back(ref4(s_init, s_b));
    cycles = 0;
    while (!s_out_valid && cycles < 200) begin
      @(posedge clk); #1; cycles++;
    end
    e = (sq.size() > 0) ? sq.pop_front() : '0;
    check($sformatf("sweep%0d_latency", idx), cycles, SW*SN);
    check($sformatf("sweep%0d_a", idx), {28'd0, s_a}, {28'd0, e.a});
    check($sformatf("sweep%0d_dz", idx), {31'd0, s_div_zero}, {31'd0, e.dz});
    @(posedge clk); #1;
    check($sformatf("sweep%0d_idle", idx), {31'd0, s_in_ready}, 32'd1);
  endtask

  initial begin
    logic [TN*TW-1:0] bv;
    int seen;

    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b1; init = '0; b = '0;
    s_in_valid = 1'b0; s_out_ready = 1'b1; s_init = '0; s_b = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_a", {22'd0, a}, 32'd0);
    check("rst_div_zero", {31'd0, div_zero}, 32'd0);

    run_job("all7", 10'd1000, mk(7, 7, 7));
    run_job("zero0", 10'd1000, mk(0, 7, 7));
    run_job("chain", 10'd1023, mk(1000, 10, 1023));
    check("chain_const", {22'd0, last_exp.a}, 32'd3);

    bv = '0;
    for (int k = 0; k < TN; k++) bv[k*TW +: TW] = TW'($urandom_range(1, 1023));
    run_job("init0", 10'd0, bv);

    // Backpressure: result held, busy, and a stray request ignored.
    out_ready = 1'b0;
    start_job(10'd1000, mk(7, 7, 7));
    wait_result("bp");
    for (int c = 0; c < 20; c++) begin
      in_valid = 1'b1;
      init = 10'd5;
      b = mk(3, 3, 3);
      @(posedge clk); #1;
      check("bp_valid", {31'd0, out_valid}, 32'd1);
      check("bp_a", {22'd0, a}, 32'd6);
      check("bp_in_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    finish_job("bp");
    repeat (5) @(posedge clk);
    #1;
    check("bp_no_stray_job", {31'd0, out_valid}, 32'd0);
    check("bp_no_stray_busy", {31'd0, in_ready}, 32'd1);

    run_job("b2b_zero", 10'd777, mk(13, 0, 511));
    run_job("b2b_clean", 10'd777, mk(13, 11, 511));

    // Reset in the middle of a job.
    start_job(10'd1023, mk(1000, 10, 1023));
    seen = 0;
    repeat (199) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    q.delete();
    check("midrst_no_valid", seen, 0);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_a", {22'd0, a}, 32'd0);
    check("midrst_div_zero", {31'd0, div_zero}, 32'd0);
    run_job("after_rst", 10'd1000, mk(7, 7, 7));

    for (int j = 0; j < 16; j++) sweep_job(j);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
`default_nettype wire
